// File: rtl/id_ex_skid_reg_if.sv
// Handshake/payload bundle between decode, the ID/EX skid register and EX.
// "slave" is the register's view; "master" is the surrounding pipeline's view.
`timescale 1ns/1ps

interface id_ex_skid_reg_if #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 10,
    parameter int RADDR_W = 5
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic [DATA_W-1:0]  pc4_i;
    logic [DATA_W-1:0]  rs_data_i;
    logic [DATA_W-1:0]  rt_data_i;
    logic [DATA_W-1:0]  imm_ext_i;
    logic [RADDR_W-1:0] wr_addr_i;
    logic [CTRL_W-1:0]  ctrl_i;

    logic               out_valid_o;
    logic               out_ready_i;
    logic [DATA_W-1:0]  pc4_o;
    logic [DATA_W-1:0]  rs_data_o;
    logic [DATA_W-1:0]  rt_data_o;
    logic [DATA_W-1:0]  imm_ext_o;
    logic [RADDR_W-1:0] wr_addr_o;
    logic [CTRL_W-1:0]  ctrl_o;

    modport slave (
        input  in_valid_i, pc4_i, rs_data_i, rt_data_i, imm_ext_i, wr_addr_i, ctrl_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o, pc4_o, rs_data_o, rt_data_o, imm_ext_o, wr_addr_o, ctrl_o
    );

    modport master (
        output in_valid_i, pc4_i, rs_data_i, rt_data_i, imm_ext_i, wr_addr_i, ctrl_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o, pc4_o, rs_data_o, rt_data_o, imm_ext_o, wr_addr_o, ctrl_o
    );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a 2-entry skid buffer (main + skid) under valid/ready.
// Define ID_EX_STALL_CNT_EN to add the 32-bit stall_cnt_o EX-stall cycle counter.
`timescale 1ns/1ps

module id_ex_skid_reg #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 10,
    parameter int RADDR_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    id_ex_skid_reg_if.slave     bus
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    localparam int PAY_W = 4 * DATA_W + RADDR_W + CTRL_W;

    logic [PAY_W-1:0] in_word;
    logic [PAY_W-1:0] main_word;
    logic [PAY_W-1:0] skid_word;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             drain;

    assign in_word = {bus.pc4_i, bus.rs_data_i, bus.rt_data_i,
                      bus.imm_ext_i, bus.wr_addr_i, bus.ctrl_i};

    // Upstream ready comes straight from the skid flop, so it never sees out_ready_i.
    assign bus.in_ready_o = ~skid_valid;
    assign accept         = bus.in_valid_i & ~skid_valid;
    assign drain          = main_valid & bus.out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_word  <= '0;
            skid_word  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                main_word  <= skid_word;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || drain) begin
            main_valid <= accept;
            if (accept) begin
                main_word <= in_word;
            end
        end else if (accept) begin
            skid_word  <= in_word;
            skid_valid <= 1'b1;
        end
    end

    assign bus.out_valid_o = main_valid;
    assign {bus.pc4_o, bus.rs_data_o, bus.rt_data_o,
            bus.imm_ext_o, bus.wr_addr_o, bus.ctrl_o} = main_word;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Counts cycles EX holds off a valid word; survives flushes, wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (main_valid && !bus.out_ready_i) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule
